mix_col_engine: RTL and testbench

MIX_COL_ENGINE -- requirements
Module: mix_col_engine

---
 rtl/mix_col_engine.sv | 121 ++++++++++++
 tb/tb_mix_col_engine.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_col_engine.sv
// AES MixColumns / InvMixColumns engine: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per BUSY cycle, then holds the result in DONE until taken.
module mix_col_engine #(
    parameter int COLS_PER_CYCLE = 4,
    parameter bit OUT_REG_RESET  = 1'b1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         InValid,
    output logic         InReady,
    input  logic [127:0] DataIn,
    input  logic         Decrypt,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] DataOut
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadCols
            $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int SLICES = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_SLICE = 2'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT        state;
    stateT        nextState;
    logic [1:0]   cnt;
    logic [127:0] blockReg;
    logic         decReg;
    logic [127:0] resultReg;
    logic [127:0] nextResult;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of b, 2b, 4b, 8b.
    function automatic logic [7:0] mulCoef(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p2;
        logic [7:0] p4;
        logic [7:0] p8;
        p2 = xtime(b);
        p4 = xtime(p2);
        p8 = xtime(p4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? p2 : 8'h00) ^
               (k[2] ? p4 : 8'h00) ^ (k[3] ? p8 : 8'h00);
    endfunction

    // Circulant matrix: row r uses coefficient (j - r) mod 4 for input byte j.
    function automatic logic [31:0] mixColumn(input logic [31:0] col, input logic inv);
        logic [15:0] coefs;
        logic [7:0]  acc;
        logic [31:0] res;
        coefs = inv ? 16'hebd9 : 16'h2311;
        res   = '0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ mulCoef(col[31 - 8*j -: 8], coefs[15 - 4*((j - r) & 3) -: 4]);
            end
            res[31 - 8*r -: 8] = acc;
        end
        return res;
    endfunction

    assign InReady  = (state == IDLE) || (state == DONE && OutReady);
    assign accept   = InValid && InReady;
    assign OutValid = (state == DONE);
    assign DataOut  = resultReg;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = BUSY;
            BUSY:    if (cnt == LAST_SLICE) nextState = DONE;
            DONE:    if (OutReady) nextState = InValid ? BUSY : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            decReg   <= 1'b0;
            blockReg <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                blockReg <= DataIn;
                decReg   <= Decrypt;
                cnt      <= 2'd0;
            end else if (state == BUSY) begin
                cnt <= (cnt == LAST_SLICE) ? 2'd0 : cnt + 2'd1;
            end
        end
    end

    // Only the current slice's columns change; the rest keep their old contents.
    always_comb begin
        nextResult = resultReg;
        for (int c = 0; c < COLS_PER_CYCLE; c++) begin
            nextResult[127 - 32*(int'(cnt)*COLS_PER_CYCLE + c) -: 32] =
                mixColumn(blockReg[127 - 32*(int'(cnt)*COLS_PER_CYCLE + c) -: 32], decReg);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst && OUT_REG_RESET) begin
            resultReg <= '0;
        end else if (!Rst && state == BUSY) begin
            resultReg <= nextResult;
        end
    end

endmodule

// File: tb/tb_mix_col_engine.sv
// Self-checking bench for mix_col_engine: four instances (C=1, C=2, C=4, and C=4
// with a non-resetting output register) checked against a GF(2^8) matrix model.
module tb_mix_col_engine;

    logic         clk;
    logic         rst      [4];
    logic         inValid  [4];
    logic         inReady  [4];
    logic [127:0] dataIn   [4];
    logic         decrypt  [4];
    logic         outValid [4];
    logic         outReady [4];
    logic [127:0] dataOut  [4];

    int vectors;
    int miscompares;

    generate
        for (genvar g = 0; g < 4; g++) begin : gDut
            localparam int CV  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
            localparam bit ORR = (g == 3) ? 1'b0 : 1'b1;
            mix_col_engine #(.COLS_PER_CYCLE(CV), .OUT_REG_RESET(ORR)) dut (
                .Clk(clk), .Rst(rst[g]), .InValid(inValid[g]), .InReady(inReady[g]),
                .DataIn(dataIn[g]), .Decrypt(decrypt[g]), .OutValid(outValid[g]),
                .OutReady(outReady[g]), .DataOut(dataOut[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int colsOf(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Generic shift-and-add GF(2^8) multiply, modulus x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] refMix(input logic [127:0] s, input logic inv);
        logic [7:0]   first [4];
        logic [7:0]   m     [4][4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) first = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     first = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                m[r][j] = first[(j - r + 4) % 4];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gfMul(m[r][j], s[127 - 32*c - 8*j -: 8]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    // Offers one block, scrambles the inputs while it is in flight, and returns
    // the first OutValid data with its latency counted from the accept cycle.
    task automatic doBlock(input int d, input logic [127:0] din, input logic dec,
                           output logic [127:0] dout, output int lat, output bit ok);
        int guard;
        guard = 0;
        lat   = 0;
        while (!inReady[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        inValid[d] = 1'b1;
        dataIn[d]  = din;
        decrypt[d] = dec;
        do begin
            @(negedge clk);
            lat++;
            inValid[d] = 1'b0;
            dataIn[d]  = rand128();
            decrypt[d] = 1'($urandom);
        end while (!outValid[d] && lat < 30);
        ok   = outValid[d];
        dout = dataOut[d];
    endtask

    task automatic checkBlock(input string name, input int d, input logic [127:0] din,
                              input logic dec, output logic [127:0] dout);
        int lat;
        bit ok;
        doBlock(d, din, dec, dout, lat, ok);
        vectors++;
        if (!ok || dout !== refMix(din, dec)) begin
            miscompares++;
            $display("[TB] FAIL %s data: got %h (valid=%0b) expected %h", name, dout, ok, refMix(din, dec));
        end
        vectors++;
        if (lat !== 1 + 4 / colsOf(d)) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, 1 + 4 / colsOf(d));
        end
    endtask

    task automatic test_reset();
        logic [127:0] r;
        for (int d = 0; d < 4; d++) rst[d] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) rst[d] = 1'b0;
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (outValid[d] !== 1'b0 || inReady[d] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reset_handshake[%0d]: got valid=%b ready=%b expected valid=0 ready=1",
                         d, outValid[d], inReady[d]);
            end
        end
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (dataOut[d] !== 128'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_dataout[%0d]: got %h expected 0", d, dataOut[d]);
            end
        end
        // A completed result must be cleared on the resetting instance and kept on the other.
        checkBlock("pre_reset_c4", 2, rand128(), 1'b0, r);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        vectors++;
        if (dataOut[2] !== 128'h0 || outValid[2] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_clears_result: got %h valid=%b expected 0 valid=0", dataOut[2], outValid[2]);
        end
        checkBlock("pre_reset_hold", 3, rand128(), 1'b1, r);
        rst[3] = 1'b1;
        @(negedge clk);
        rst[3] = 1'b0;
        vectors++;
        if (dataOut[3] !== r || outValid[3] !== 1'b0 || inReady[3] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_holds_result: got %h valid=%b ready=%b expected %h valid=0 ready=1",
                     dataOut[3], outValid[3], inReady[3], r);
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] r;
        checkBlock("fips_forward_c4", 2, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, r);
        vectors++;
        if (r !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            miscompares++;
            $display("[TB] FAIL fips_forward_const: got %h expected 8e4da1bc9fdc589d01010101c6c6c6c6", r);
        end
        checkBlock("fips_inverse_c1", 0, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, r);
        vectors++;
        if (r !== 128'hdb135345_f20a225c_d4d4d4d5_2d26314c) begin
            miscompares++;
            $display("[TB] FAIL fips_inverse_const: got %h expected db135345f20a225cd4d4d4d52d26314c", r);
        end
    endtask

    task automatic test_random();
        logic [127:0] r;
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 4; i++)
                checkBlock($sformatf("random_d%0d_%0d", d, i), d, rand128(), 1'($urandom), r);
    endtask

    task automatic test_stall();
        logic [127:0] din;
        logic [127:0] held;
        int lat;
        bit ok;
        din = rand128();
        outReady[1] = 1'b0;
        doBlock(1, din, 1'b0, held, lat, ok);
        vectors++;
        if (!ok || held !== refMix(din, 1'b0) || lat !== 3) begin
            miscompares++;
            $display("[TB] FAIL stall_first: got %h lat=%0d expected %h lat=3", held, lat, refMix(din, 1'b0));
        end
        for (int i = 0; i < 10; i++) begin
            inValid[1] = 1'(i % 2);
            dataIn[1]  = rand128();
            decrypt[1] = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (dataOut[1] !== held || outValid[1] !== 1'b1 || inReady[1] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_%0d: got %h valid=%b ready=%b expected %h valid=1 ready=0",
                         i, dataOut[1], outValid[1], inReady[1], held);
            end
        end
        inValid[1]  = 1'b0;
        outReady[1] = 1'b1;
        @(negedge clk);
        vectors++;
        if (outValid[1] !== 1'b0 || inReady[1] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got valid=%b ready=%b expected valid=0 ready=1",
                     outValid[1], inReady[1]);
        end
    endtask

    // With both sides always ready the period is the slice cycles plus the
    // DONE/accept cycle, with no idle bubble between blocks.
    task automatic test_back_to_back();
        logic [127:0] expQ[$];
        int  cyc;
        int  prevCyc;
        int  results;
        bit  lastAcc;
        cyc     = 0;
        prevCyc = -1;
        results = 0;
        outReady[1] = 1'b1;
        inValid[1]  = 1'b1;
        dataIn[1]   = rand128();
        decrypt[1]  = 1'b0;
        lastAcc = inReady[1];
        if (lastAcc) expQ.push_back(refMix(dataIn[1], decrypt[1]));
        while (results < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (outValid[1]) begin
                vectors++;
                if (expQ.size() == 0 || dataOut[1] !== expQ[0]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_data_%0d: got %h expected %h", results, dataOut[1],
                             (expQ.size() == 0) ? 128'hx : expQ[0]);
                end
                if (expQ.size() != 0) void'(expQ.pop_front());
                if (prevCyc >= 0) begin
                    vectors++;
                    if (cyc - prevCyc !== 3) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_period_%0d: got %0d cycles expected 3", results, cyc - prevCyc);
                    end
                end
                prevCyc = cyc;
                results++;
            end
            if (lastAcc) begin
                dataIn[1]  = rand128();
                decrypt[1] = ~decrypt[1];
            end
            lastAcc = inReady[1];
            if (lastAcc) expQ.push_back(refMix(dataIn[1], decrypt[1]));
        end
        inValid[1] = 1'b0;
        vectors++;
        if (results < 6) begin
            miscompares++;
            $display("[TB] FAIL b2b_timeout: got %0d results expected 6", results);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_busy();
        logic [127:0] r;
        bit seen;
        vectors++;
        if (inReady[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstbusy_ready: got %b expected 1", inReady[0]);
        end
        inValid[0] = 1'b1;
        dataIn[0]  = rand128();
        decrypt[0] = 1'b0;
        @(negedge clk);
        inValid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        vectors++;
        if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || dataOut[0] !== 128'h0) begin
            miscompares++;
            $display("[TB] FAIL rstbusy_after: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=0",
                     outValid[0], inReady[0], dataOut[0]);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (outValid[0]) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstbusy_ghost: got OutValid=1 expected no result for discarded block");
        end
        checkBlock("rstbusy_next", 0, rand128(), 1'b1, r);
    endtask

    task automatic test_roundtrip();
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] z;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 3; i++) begin
                x = rand128();
                checkBlock($sformatf("rt_fwd_d%0d", d), d, x, 1'b0, y);
                checkBlock($sformatf("rt_inv_d%0d", d), d, y, 1'b1, z);
                vectors++;
                if (z !== x) begin
                    miscompares++;
                    $display("[TB] FAIL roundtrip_d%0d_%0d: got %h expected %h", d, i, z, x);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int d = 0; d < 4; d++) begin
            rst[d]      = 1'b1;
            inValid[d]  = 1'b0;
            dataIn[d]   = '0;
            decrypt[d]  = 1'b0;
            outReady[d] = 1'b1;
        end
        test_reset();
        test_known_vectors();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_busy();
        test_roundtrip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
